// File: rtl/logic_gate_sweep.sv
`default_nettype none
// ============================================================================
// Module   : logic_gate_sweep
// Brief    : Mode-selectable N-input gate that walks every input combination,
//            streams each row out on valid/ready and builds its truth table.
// Revision : 1.0
// ============================================================================
module logic_gate_sweep #(
    parameter  int N_IN = 2,
    localparam int ROWS = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            row_ready,
    output logic            busy,
    output logic            done,
    output logic            row_valid,
    output logic [N_IN-1:0] row_a,
    output logic            row_y,
    output logic [ROWS-1:0] truth_table
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EMIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [N_IN-1:0] c_LAST_IDX = N_IN'(ROWS - 1);
    localparam logic [N_IN-1:0] c_ONE      = N_IN'(1);

    localparam logic [2:0] c_MODE_AND  = 3'b000;
    localparam logic [2:0] c_MODE_OR   = 3'b001;
    localparam logic [2:0] c_MODE_NAND = 3'b010;
    localparam logic [2:0] c_MODE_NOR  = 3'b011;
    localparam logic [2:0] c_MODE_XOR  = 3'b100;
    localparam logic [2:0] c_MODE_XNOR = 3'b101;
    localparam logic [2:0] c_MODE_BUF  = 3'b110;

    logic [1:0]      r_state_q,       w_state_d;
    logic [N_IN-1:0] r_idx_q,         w_idx_d;
    logic [2:0]      r_mode_q,        w_mode_d;
    logic [ROWS-1:0] r_truth_table_q, w_truth_table_d;
    logic            r_row_valid_q,   w_row_valid_d;
    logic [N_IN-1:0] r_row_a_q,       w_row_a_d;
    logic            r_row_y_q,       w_row_y_d;
    logic            r_done_q,        w_done_d;

    logic            w_handshake;
    logic            w_last_row;
    logic [N_IN-1:0] w_idx_inc;

    // Gate function evaluated over the whole input vector; BUF/NOT use bit 0 only.
    function automatic logic gate_eval(input logic [2:0] m, input logic [N_IN-1:0] a);
        logic y;
        case (m)
            c_MODE_AND:  y = &a;
            c_MODE_OR:   y = |a;
            c_MODE_NAND: y = ~(&a);
            c_MODE_NOR:  y = ~(|a);
            c_MODE_XOR:  y = ^a;
            c_MODE_XNOR: y = ~(^a);
            c_MODE_BUF:  y = a[0];
            default:     y = ~a[0];
        endcase
        return y;
    endfunction

    assign w_handshake = r_row_valid_q & row_ready;
    assign w_last_row  = (r_idx_q == c_LAST_IDX);
    assign w_idx_inc   = r_idx_q + c_ONE;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= c_IDLE;
            r_idx_q         <= '0;
            r_mode_q        <= '0;
            r_truth_table_q <= '0;
            r_row_valid_q   <= 1'b0;
            r_row_a_q       <= '0;
            r_row_y_q       <= 1'b0;
            r_done_q        <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_idx_q         <= w_idx_d;
            r_mode_q        <= w_mode_d;
            r_truth_table_q <= w_truth_table_d;
            r_row_valid_q   <= w_row_valid_d;
            r_row_a_q       <= w_row_a_d;
            r_row_y_q       <= w_row_y_d;
            r_done_q        <= w_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE: begin
                if (start) begin
                    w_state_d = c_EMIT;
                end
            end
            c_EMIT: begin
                if (w_handshake && w_last_row) begin
                    w_state_d = c_DONE;
                end
            end
            c_DONE: begin
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    // Next-value logic for the registered outputs and datapath; idx is left
    // untouched on the way out of DONE.
    always_comb begin
        w_idx_d         = r_idx_q;
        w_mode_d        = r_mode_q;
        w_truth_table_d = r_truth_table_q;
        w_row_valid_d   = r_row_valid_q;
        w_row_a_d       = r_row_a_q;
        w_row_y_d       = r_row_y_q;
        w_done_d        = 1'b0;
        case (r_state_q)
            c_IDLE: begin
                w_row_valid_d = 1'b0;
                if (start) begin
                    w_mode_d        = mode;
                    w_idx_d         = '0;
                    w_truth_table_d = '0;
                    w_row_valid_d   = 1'b1;
                    w_row_a_d       = '0;
                    w_row_y_d       = gate_eval(mode, '0);
                end
            end
            c_EMIT: begin
                if (w_handshake) begin
                    w_truth_table_d[r_idx_q] = r_row_y_q;
                    if (w_last_row) begin
                        w_row_valid_d = 1'b0;
                        w_done_d      = 1'b1;
                    end else begin
                        w_idx_d   = w_idx_inc;
                        w_row_a_d = w_idx_inc;
                        w_row_y_d = gate_eval(r_mode_q, w_idx_inc);
                    end
                end
            end
            c_DONE: begin
                w_row_valid_d = 1'b0;
            end
            default: begin
                w_row_valid_d = 1'b0;
            end
        endcase
    end

    assign busy        = (r_state_q != c_IDLE);
    assign done        = r_done_q;
    assign row_valid   = r_row_valid_q;
    assign row_a       = r_row_a_q;
    assign row_y       = r_row_y_q;
    assign truth_table = r_truth_table_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_sweep.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_gate_sweep
// Brief    : Scoreboard bench for logic_gate_sweep with randomised modes,
//            back-pressure and spurious start pulses.
// Revision : 1.0
// ============================================================================
module tb_logic_gate_sweep;

    localparam int N    = 3;
    localparam int ROWS = 1 << N;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      mode;
    logic            row_ready;
    logic            busy;
    logic            done;
    logic            row_valid;
    logic [N-1:0]    row_a;
    logic            row_y;
    logic [ROWS-1:0] truth_table;

    logic_gate_sweep #(.N_IN(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .row_ready  (row_ready),
        .busy       (busy),
        .done       (done),
        .row_valid  (row_valid),
        .row_a      (row_a),
        .row_y      (row_y),
        .truth_table(truth_table)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] a;
        logic         y;
    } row_t;

    typedef struct {
        logic [ROWS-1:0] tbl;
        int              done_cyc;
    } sweep_t;

    row_t   row_q[$];
    sweep_t sweep_q[$];
    bit     sb_off = 1'b0;
    int     checks = 0;
    int     failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference gate: defined by counting ones in the input vector.
    function automatic logic ref_gate(input int m, input int a);
        int ones;
        ones = $countones(a);
        case (m)
            0:       return ones == N;
            1:       return ones != 0;
            2:       return ones != N;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            6:       return (a % 2) == 1;
            default: return (a % 2) == 0;
        endcase
    endfunction

    // Monitor: compares every handshake row and every done pulse with the queues.
    bit           held_v = 1'b0;
    logic [N-1:0] held_a;
    logic         held_y;
    row_t         mon_row;
    sweep_t       mon_sw;

    always @(negedge clk) begin
        if (!rst && !sb_off) begin
            if (held_v) begin
                check("hold_row_valid", row_valid, 1);
                check("hold_row_a", row_a, held_a);
                check("hold_row_y", row_y, held_y);
            end
            held_v = row_valid && !row_ready;
            held_a = row_a;
            held_y = row_y;
            if (row_valid && row_ready) begin
                if (row_q.size() == 0) begin
                    check("row_unexpected", 1, 0);
                end else begin
                    mon_row = row_q.pop_front();
                    check("row_a", row_a, mon_row.a);
                    check("row_y", row_y, mon_row.y);
                end
            end
            if (done) begin
                if (sweep_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mon_sw = sweep_q.pop_front();
                    check("done_cycle", cyc, mon_sw.done_cyc);
                    check("done_table", truth_table, mon_sw.tbl);
                    check("done_busy", busy, 1);
                    check("done_row_valid", row_valid, 0);
                    check("done_rows_left", row_q.size(), 0);
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic run_sweep(input int m, input bit all_ready, input bit hop);
        bit              rdy[$];
        int              k;
        int              jl;
        int              e0;
        int              w;
        logic [ROWS-1:0] tbl;
        row_t            r;
        sweep_t          s;
        k = 0;
        while (k < ROWS) begin
            bit b;
            b = all_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdy.push_back(b);
            if (b) k++;
        end
        jl = rdy.size() - 1;
        for (int i = 0; i < ROWS; i++) begin
            tbl[i] = ref_gate(m, i);
            r.a    = i[N-1:0];
            r.y    = tbl[i];
            row_q.push_back(r);
        end
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m[2:0];
        @(posedge clk); #1;
        start = 1'b0;
        e0    = cyc;
        s.tbl = tbl;
        s.done_cyc = e0 + jl + 1;
        sweep_q.push_back(s);
        check("busy_after_start", busy, 1);
        check("table_cleared", truth_table, 0);
        for (int j = 0; j <= jl; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            row_ready = rdy[j];
            if (hop) begin
                start = ($urandom_range(0, 2) == 0);
                mode  = 3'($urandom);
            end
        end
        @(posedge clk); #1;
        start     = 1'b0;
        row_ready = 1'($urandom);
        w = 0;
        while (sweep_q.size() != 0 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (sweep_q.size() != 0) begin
            check("done_timeout", 0, 1);
            sweep_q.delete();
            row_q.delete();
        end
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_table_hold", truth_table, tbl);
    endtask

    task automatic mid_reset();
        bit saw_done;
        sb_off    = 1'b1;
        row_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 3'b011;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_row_valid", row_valid, 0);
        check("rst_done", done, 0);
        check("rst_table", truth_table, 0);
        check("rst_row_a", row_a, 0);
        check("rst_row_y", row_y, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("rst_no_restart", saw_done, 0);
        sb_off = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 3'b000;
        row_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_row_valid", row_valid, 0);
        check("reset_row_a", row_a, 0);
        check("reset_row_y", row_y, 0);
        check("reset_table", truth_table, 0);
        rst = 1'b0;

        run_sweep(4, 1'b1, 1'b0);
        check("xor_table_literal", truth_table, 8'b1001_0110);
        run_sweep(3, 1'b1, 1'b0);
        check("nor_table_literal", truth_table, 8'b0000_0001);
        run_sweep(7, 1'b0, 1'b0);
        check("not_table_literal", truth_table, 8'b0101_0101);
        run_sweep(0, 1'b1, 1'b0);
        check("and_table_literal", truth_table, 8'b1000_0000);
        mid_reset();
        run_sweep(3, 1'b0, 1'b1);
        for (int n = 0; n < 16; n++) begin
            run_sweep($urandom_range(0, 7), 1'b0, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/logic_gate_sweep.md
Name: logic_gate_sweep

Overview:
Parametrised, mode-selectable N-input logic gate with a built-in truth-table sequencer. On `start` it walks every input combination 0..2^N_IN-1, one row at a time. Each row goes out on a valid/ready stream and is accumulated into a truth-table register. This is the hardware successor to the fixed 2-input gates and their exhaustive benches: it provides on-chip gate self-characterisation and a reusable stimulus source.

Parameters:
N_IN, 2, number of gate inputs; legal range 2..6.
ROWS, 2**N_IN, derived (localparam); number of truth-table rows.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  sweep request; sampled only in IDLE
mode  input  3  gate function; latched when start is accepted
row_ready  input  1  downstream accepts current row
busy  output  1  high while a sweep is in progress (state != IDLE)
done  output  1  one-cycle pulse after the last row handshake
row_valid  output  1  current row is presented
row_a  output  N_IN  input vector of current row (= row index)
row_y  output  1  gate output for row_a under the latched mode
truth_table  output  ROWS  bit i = gate output for input vector i

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high (rst).
- Reset: state=IDLE, idx=0, mode_q=0, busy=0, done=0, row_valid=0, row_a=0, row_y=0, truth_table=0.
- Mode encoding, applied over all N_IN bits of row_a:
  - 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR (odd parity), 101 XNOR.
  - 110 BUF a[0], 111 NOT a[0].
- FSM states: IDLE, EMIT, DONE.
- IDLE:
  - start=1 at edge t: mode_q<=mode, idx<=0, truth_table<=0, go to EMIT.
  - Otherwise stay in IDLE.
- EMIT:
  - row_valid=1, row_a=idx, row_y=f(mode_q, idx).
  - All three outputs are registered; the first row appears at cycle t+1.
  - Handshake occurs at an edge where row_valid & row_ready: truth_table[idx]<=row_y.
    - If idx==ROWS-1, go to DONE.
    - Else idx<=idx+1, and the next row is presented the following cycle.
  - row_ready=0: row_valid, row_a and row_y hold stable; no table write.
  - No bubble cycles: with row_ready held high, row k is presented at cycle t+1+k.
- DONE:
  - Lasts exactly one cycle. done=1, row_valid=0, busy=1.
  - Then return to IDLE; idx is not reset.
  - With ready continuously high, done is asserted at cycle t+1+ROWS.
- start is ignored in EMIT and DONE; it is not queued.
- mode changes after acceptance have no effect until the next accepted start.
- truth_table:
  - Holds its value in IDLE until the next accepted start.
  - Partially filled while EMIT is in progress.
  - Unwritten bits read 0.
- idx counter: width N_IN, with no wrap past ROWS-1 (the transition to DONE occurs first).
- rst asserted mid-sweep: all outputs return to reset values on that edge, and the sweep is abandoned. A new start is needed.
- start and rst high together: rst wins.

Test Plan:
1. N_IN=2, mode=011 (NOR), row_ready tied 1, start pulsed at cycle 0:
   - rows (row_a,row_y) = (00,1),(01,0),(10,0),(11,0) at cycles 1..4.
   - done=1 at cycle 5 only; truth_table=4'b0001; busy high cycles 1..5.
2. N_IN=2, NOR, row_ready low on cycles 2–3:
   - row 01 is held on cycles 2–4 with stable row_a/row_y; no table bit 1 write before cycle 4.
   - done at cycle 7; final truth_table=4'b0001.
3. N_IN=3, mode=100 (XOR), ready=1:
   - truth_table=8'b10010110; 8 rows; done at cycle start+9.
4. N_IN=2, mode=111 (NOT a[0]):
   - truth_table=4'b0101.
   - Repeat with mode=000 (AND): truth_table=4'b1000, and the previous table is cleared at start.
5. Start a NOR sweep, then toggle mode to 000 and pulse start on cycle 2:
   - the sweep completes unchanged (4'b0001, done at cycle 5); the second start is ignored.
6. Assert rst at cycle 3 of a sweep:
   - cycle 4: busy=0, row_valid=0, truth_table=0, done never pulses.
   - A subsequent start runs a full, correct sweep.
